alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters (e.g. integer pipe and address-generation/branch unit).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitrates and captures operands, then drives the internal ALU instance from registered operands and returns a registered result and zero flag.
- One operation in flight at a time.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = requester 0 always wins when both request.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  32  operand A
- req0_b  input  32  operand B
- req0_op  input  4  ALU control code (0000 ADD … 1001 SLT)
- rsp0_valid  output  1  result for requester 0 available
- rsp0_ready  input  1  requester 0 consumes result
- rsp0_result  output  32  registered ALU result
- rsp0_zero  output  1  registered zero flag
- rsp0_err  output  1  op code was illegal (>1001)
- req1_*, rsp1_*  same set as requester 0, identical meaning

Behaviour:
- Reset values (async, immediate on rst):
  - state = IDLE; all req*_ready = 0; all rsp*_valid = 0.
  - rsp*_result = 0, rsp*_zero = 0, rsp*_err = 0.
  - last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valids only, never from ready.
  - If both valid: with FIXED_PRIO = 0, grant goes to the requester not equal to last_grant; with FIXED_PRIO = 1, grant goes to requester 0.
  - If only one is valid, that one is granted.
  - reqN_ready = (state == IDLE) && grantN. At most one ready is high per cycle.
  - On handshake (valid && ready): capture a, b, op and the grant index; last_grant <= index; go to EXEC.
- EXEC (1 cycle):
  - Captured operands drive the ALU.
  - Legal op: result and zero registered into the granted requester's rsp registers, err = 0.
  - Illegal op (1010–1111): result = 0, zero = 0, err = 1. The ALU x-output is never propagated.
  - rspN_valid <= 1; go to RESP.
- RESP:
  - rspN_valid, result, zero and err are held stable until rspN_ready = 1.
  - On that cycle: rspN_valid <= 0; go to IDLE.
  - No new request is accepted in RESP, including the cycle rsp_ready is seen.
  - The other requester's rsp outputs remain unchanged.
- Latency and throughput:
  - Request handshake in cycle T gives rsp_valid high at T+2.
  - Minimum 3 cycles per operation, with rsp_ready held high.
- Protocol rules:
  - Requesters hold valid and operands stable until ready. The arbiter must not drop an outstanding grant in IDLE while valid stays high.
  - Deasserting valid before ready is a protocol violation; the arbiter simply re-arbitrates.
  - rsp*_result, rsp*_zero and rsp*_err of a non-granted requester keep their last value; they are meaningful only while that requester's rsp_valid = 1.
- Arithmetic is entirely per the ALU codes:
  - shift amounts use B[4:0];
  - SLTU is unsigned, SLT is signed;
  - ADD/SUB wrap modulo 2^32.
- Reset mid-operation (EXEC or RESP):
  - Operation discarded; rsp_valid drops immediately; no response is ever produced for it.
  - After reset release, requester 0 is granted first.

Test Plan:
- Single add: req0 ADD A=5, B=3 handshake at T → rsp0_valid at T+2, result = 8, zero = 0, err = 0; req1 side idle throughout.
- Zero flag and round-robin: both valid continuously, req0 SUB 7−7, req1 SLT A=0xFFFFFFFF, B=1 → order is req0 (result 0, zero = 1), then req1 (result 1), then req0 again; grants strictly alternate over 6 operations.
- Backpressure: rsp1_ready held low 4 cycles after rsp1_valid with req0_valid high → rsp1 values stable, req0_ready stays 0; accept req0 only one cycle after the rsp1 handshake.
- Illegal op: req0_op = 4'b1111, A = 1, B = 1 → rsp0_err = 1, result = 0, zero = 0, no X on any output; next legal SRA 0x80000000 >> 4 → 0xF8000000, err = 0.
- Reset in EXEC: assert rst one cycle after a req1 handshake → all rsp*_valid = 0 immediately, no response after release; with both valid, first grant is req0.
- FIXED_PRIO = 1: both valid for 5 operations → all 5 grants to req0, req1_ready never asserted; drop req0_valid → req1 served with rsp1_valid 2 cycles after its handshake.

Source files
------------

// File: rtl/alu_share_if.sv
// One requester's link to the shared ALU: a request channel in and a response channel out.
interface alu_share_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter around one combinational 32-bit ALU; one operation in flight,
// IDLE -> EXEC -> RESP, registered operands and registered per-requester responses.
module alu_share_alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        illegal
);
  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      4'd0: y = a + b;
      4'd1: y = a - b;
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = a << b[4:0];
      4'd6: y = a >> b[4:0];
      4'd7: y = 32'($signed(a) >>> b[4:0]);
      4'd8: y = {31'b0, a < b};
      4'd9: y = {31'b0, $signed(a) < $signed(b)};
      default: illegal = 1'b1;
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic       clk,
  input logic       rst,
  alu_share_if.slave port0,
  alu_share_if.slave port1
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant, gnt_q, grant;
  logic [31:0]      a_q, b_q, alu_y;
  logic [3:0]       op_q;
  logic             alu_illegal;

  logic [1:0]       valid, ready, rsp_ready;
  logic [1:0][31:0] a_in, b_in;
  logic [1:0][3:0]  op_in;
  logic [1:0]       rsp_valid, rsp_zero, rsp_err;
  logic [1:0][31:0] rsp_result;

  assign valid     = {port1.req_valid, port0.req_valid};
  assign a_in      = {port1.req_a, port0.req_a};
  assign b_in      = {port1.req_b, port0.req_b};
  assign op_in     = {port1.req_op, port0.req_op};
  assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};

  assign port0.req_ready  = ready[0];
  assign port1.req_ready  = ready[1];
  assign port0.rsp_valid  = rsp_valid[0];
  assign port1.rsp_valid  = rsp_valid[1];
  assign port0.rsp_result = rsp_result[0];
  assign port1.rsp_result = rsp_result[1];
  assign port0.rsp_zero   = rsp_zero[0];
  assign port1.rsp_zero   = rsp_zero[1];
  assign port0.rsp_err    = rsp_err[0];
  assign port1.rsp_err    = rsp_err[1];

  // Grant depends only on the valids, so a held request keeps its grant until taken.
  always_comb begin
    if (&valid) grant = FIXED_PRIO ? 1'b0 : ~last_grant;
    else        grant = valid[1];
    ready[0] = !rst && (state == IDLE) && valid[0] && !grant;
    ready[1] = !rst && (state == IDLE) && valid[1] &&  grant;
  end

  alu_share_alu u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .y       (alu_y),
    .illegal (alu_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= '0;
      rsp_err    <= '0;
    end else begin
      case (state)
        IDLE: if (|(valid & ready)) begin
          a_q        <= a_in[grant];
          b_q        <= b_in[grant];
          op_q       <= op_in[grant];
          gnt_q      <= grant;
          last_grant <= grant;
          state      <= EXEC;
        end
        EXEC: begin
          // Illegal codes report a clean zero result, never the ALU's raw output.
          rsp_valid[gnt_q]  <= 1'b1;
          rsp_result[gnt_q] <= alu_illegal ? 32'd0 : alu_y;
          rsp_zero[gnt_q]   <= !alu_illegal && (alu_y == 32'd0);
          rsp_err[gnt_q]    <= alu_illegal;
          state             <= RESP;
        end
        RESP: if (rsp_ready[gnt_q]) begin
          rsp_valid[gnt_q] <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: round-robin and fixed-priority instances share
// one stimulus; a scoreboard queue holds expected responses in grant order.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       r_valid, r_rsp_ready;
  logic [1:0][31:0] r_a, r_b;
  logic [1:0][3:0]  r_op;

  logic [1:0]       m_ready, m_rsp_valid, m_zero, m_err;
  logic [1:0][31:0] m_result;

  alu_share_if a0 (), a1 (), b0 (), b1 ();

  assign a0.req_valid = r_valid[0];  assign b0.req_valid = r_valid[0];
  assign a1.req_valid = r_valid[1];  assign b1.req_valid = r_valid[1];
  assign a0.req_a = r_a[0];          assign b0.req_a = r_a[0];
  assign a1.req_a = r_a[1];          assign b1.req_a = r_a[1];
  assign a0.req_b = r_b[0];          assign b0.req_b = r_b[0];
  assign a1.req_b = r_b[1];          assign b1.req_b = r_b[1];
  assign a0.req_op = r_op[0];        assign b0.req_op = r_op[0];
  assign a1.req_op = r_op[1];        assign b1.req_op = r_op[1];
  assign a0.rsp_ready = r_rsp_ready[0]; assign b0.rsp_ready = r_rsp_ready[0];
  assign a1.rsp_ready = r_rsp_ready[1]; assign b1.rsp_ready = r_rsp_ready[1];

  assign m_ready[0]     = sel ? b0.req_ready  : a0.req_ready;
  assign m_ready[1]     = sel ? b1.req_ready  : a1.req_ready;
  assign m_rsp_valid[0] = sel ? b0.rsp_valid  : a0.rsp_valid;
  assign m_rsp_valid[1] = sel ? b1.rsp_valid  : a1.rsp_valid;
  assign m_result[0]    = sel ? b0.rsp_result : a0.rsp_result;
  assign m_result[1]    = sel ? b1.rsp_result : a1.rsp_result;
  assign m_zero[0]      = sel ? b0.rsp_zero   : a0.rsp_zero;
  assign m_zero[1]      = sel ? b1.rsp_zero   : a1.rsp_zero;
  assign m_err[0]       = sel ? b0.rsp_err    : a0.rsp_err;
  assign m_err[1]       = sel ? b1.rsp_err    : a1.rsp_err;

  alu_share_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst(rst), .port0(a0.slave), .port1(a1.slave));
  alu_share_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst(rst), .port0(b0.slave), .port1(b1.slave));

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_log[$];
  int   checks = 0;
  int   passed = 0;

  // Reference ALU: returns {err, zero, result}.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        bad;
    r = 32'd0;
    bad = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = 32'($signed(a) >>> b[4:0]);
      4'd8: r = (a < b) ? 32'd1 : 32'd0;
      4'd9: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: bad = 1'b1;
    endcase
    return {bad, !bad && (r == 32'd0), r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Settle, score responses consumed and requests accepted at the coming edge, then step.
  task automatic cyc();
    exp_t e;
    logic [33:0] m;
    #1;
    chk("one_ready", {31'b0, m_ready[0] & m_ready[1]}, 32'd0);
    for (int n = 0; n < 2; n++) begin
      if (m_rsp_valid[n] && r_rsp_ready[n]) begin
        if (exp_q.size() == 0) chk("sb_unexpected_rsp", 32'(n), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(n), 32'(e.id));
          chk("rsp_result", m_result[n], e.res);
          chk("rsp_zero", {31'b0, m_zero[n]}, {31'b0, e.zero});
          chk("rsp_err", {31'b0, m_err[n]}, {31'b0, e.err});
        end
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (r_valid[n] && m_ready[n]) begin
        m = model(r_op[n], r_a[n], r_b[n]);
        exp_q.push_back('{n, m[31:0], m[32], m[33]});
        gnt_log.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int n);
    #1;
    for (int k = 0; k < 20; k++) begin
      if (m_ready[n]) break;
      cyc();
    end
    chk("wait_ready", {31'b0, m_ready[n]}, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0 && m_rsp_valid == 2'b00) break;
      cyc();
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    gnt_log.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    r_valid = 2'b01; r_rsp_ready = 2'b11;
    r_a = '0; r_b = '0; r_op = '0;
    @(posedge clk); #2;
    // Reset state, with a request already pending.
    chk("rst_ready0", {31'b0, m_ready[0]}, 32'd0);
    chk("rst_rsp_valid", {30'b0, m_rsp_valid}, 32'd0);
    chk("rst_result0", m_result[0], 32'd0);
    chk("rst_zero_err", {30'b0, m_zero | m_err}, 32'd0);
    r_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ADD 5+3 with two-cycle latency.
    r_a[0] = 32'd5; r_b[0] = 32'd3; r_op[0] = 4'd0; r_valid[0] = 1'b1;
    wait_ready(0);
    cyc();
    r_valid[0] = 1'b0;
    chk("add_t1_valid", {31'b0, m_rsp_valid[0]}, 32'd0);
    cyc();
    chk("add_t2_valid", {31'b0, m_rsp_valid[0]}, 32'd1);
    chk("add_result", m_result[0], 32'd8);
    chk("add_zero_err", {30'b0, m_zero[0], m_err[0]}, 32'd0);
    chk("add_rsp1_idle", {31'b0, m_rsp_valid[1]}, 32'd0);
    drain();

    // Round-robin with both valid: SUB 7-7 vs SLT -1<1.
    do_reset();
    r_a[0] = 32'd7; r_b[0] = 32'd7; r_op[0] = 4'd1;
    r_a[1] = 32'hFFFF_FFFF; r_b[1] = 32'd1; r_op[1] = 4'd9;
    r_valid = 2'b11;
    for (int k = 0; k < 40 && gnt_log.size() < 6; k++) cyc();
    r_valid = 2'b00;
    drain();
    chk("rr_count", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk("rr_order", 32'(gnt_log[i]), 32'(i % 2));

    // Backpressure on rsp1 while req0 waits.
    r_a[1] = 32'd10; r_b[1] = 32'd20; r_op[1] = 4'd0; r_rsp_ready[1] = 1'b0;
    r_valid[1] = 1'b1;
    wait_ready(1);
    cyc();
    r_valid[1] = 1'b0;
    r_a[0] = 32'h0000_F0F0; r_b[0] = 32'h0000_0FF0; r_op[0] = 4'd4; r_valid[0] = 1'b1;
    #1;
    chk("bp_exec_ready0", {31'b0, m_ready[0]}, 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp1_valid", {31'b0, m_rsp_valid[1]}, 32'd1);
      chk("bp_rsp1_result", m_result[1], 32'd30);
      chk("bp_ready0", {31'b0, m_ready[0]}, 32'd0);
      cyc();
    end
    r_rsp_ready[1] = 1'b1;
    #1;
    chk("bp_hs_ready0", {31'b0, m_ready[0]}, 32'd0);
    cyc();
    chk("bp_after_ready0", {31'b0, m_ready[0]}, 32'd1);
    cyc();
    r_valid[0] = 1'b0;
    drain();

    // Illegal op, then SRA.
    r_a[0] = 32'd1; r_b[0] = 32'd1; r_op[0] = 4'hF; r_valid[0] = 1'b1;
    wait_ready(0);
    cyc();
    r_valid[0] = 1'b0;
    cyc();
    chk("ill_valid", {31'b0, m_rsp_valid[0]}, 32'd1);
    chk("ill_err", {31'b0, m_err[0]}, 32'd1);
    chk("ill_result", m_result[0], 32'd0);
    chk("ill_zero", {31'b0, m_zero[0]}, 32'd0);
    chk("ill_no_x", {31'b0, $isunknown({m_ready, m_rsp_valid, m_result, m_zero, m_err})}, 32'd0);
    drain();
    r_a[0] = 32'h8000_0000; r_b[0] = 32'd4; r_op[0] = 4'd7; r_valid[0] = 1'b1;
    wait_ready(0);
    cyc();
    r_valid[0] = 1'b0;
    cyc();
    chk("sra_result", m_result[0], 32'hF800_0000);
    chk("sra_err", {31'b0, m_err[0]}, 32'd0);
    drain();

    // Reset during EXEC, then during RESP.
    r_a[1] = 32'd2; r_b[1] = 32'd2; r_op[1] = 4'd0; r_valid[1] = 1'b1;
    wait_ready(1);
    cyc();
    r_valid[1] = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_exec_valid", {30'b0, m_rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_exec_no_rsp", {30'b0, m_rsp_valid}, 32'd0);
      cyc();
    end
    r_rsp_ready[1] = 1'b0; r_valid[1] = 1'b1;
    wait_ready(1);
    cyc();
    r_valid[1] = 1'b0;
    cyc();
    chk("rst_resp_pre", {31'b0, m_rsp_valid[1]}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_resp_valid", {31'b0, m_rsp_valid[1]}, 32'd0);
    chk("rst_resp_result", m_result[1], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    r_rsp_ready = 2'b11;
    gnt_log.delete();
    r_valid = 2'b11;
    #1;
    chk("rst_first_ready0", {31'b0, m_ready[0]}, 32'd1);
    chk("rst_first_ready1", {31'b0, m_ready[1]}, 32'd0);
    for (int k = 0; k < 20 && gnt_log.size() < 2; k++) cyc();
    r_valid = 2'b00;
    drain();
    chk("rst_first_grant", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF_FFFF, 32'd0);

    // Fixed-priority instance.
    sel = 1'b1;
    do_reset();
    r_a[0] = 32'd1; r_b[0] = 32'd2; r_op[0] = 4'd0;
    r_a[1] = 32'h00F0; r_b[1] = 32'h0F00; r_op[1] = 4'd3;
    r_valid = 2'b11;
    for (int k = 0; k < 40 && gnt_log.size() < 5; k++) begin
      #1;
      chk("fp_no_ready1", {31'b0, m_ready[1]}, 32'd0);
      cyc();
    end
    r_valid[0] = 1'b0;
    chk("fp_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < gnt_log.size(); i++) chk("fp_grant0", 32'(gnt_log[i]), 32'd0);
    wait_ready(1);
    cyc();
    r_valid[1] = 1'b0;
    chk("fp_r1_t1", {31'b0, m_rsp_valid[1]}, 32'd0);
    cyc();
    chk("fp_r1_t2", {31'b0, m_rsp_valid[1]}, 32'd1);
    chk("fp_r1_result", m_result[1], 32'h0FF0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
